// File: rtl/uart_xmt_if.sv
// uart_xmt_if: host-side byte handshake into the UART transmitter.
// data/valid driven by host (master), ready returned by uart_xmt (slave).
interface uart_xmt_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/uart_xmt.sv
// uart_xmt: 8N1 UART transmitter (8E1 with UART_XMT_PARITY_EN), LSB first.
// Ports: clk, rst_n (async low), host (uart_xmt_if.slave: data/valid/ready),
//        txd_out (serial line, idle 1), busy (frame running or hold full).
// Optional: define UART_XMT_PARITY_EN to append an even-parity bit.
module uart_xmt #(
   parameter int WAIT_TIME = 868,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_xmt_if.slave  host,
   output logic       txd_out,
   output logic       busy
);

   localparam int CW = $clog2(WAIT_TIME + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_TIME - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_XMT_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cycle_cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic [7:0]    hold;
   logic          hold_full;
   logic          bit_end;
   logic          accept;
   logic          load;
   logic          txd_n;

   assign host.ready = ~hold_full;
   assign accept     = host.valid & ~hold_full;
   assign bit_end    = (cycle_cnt == LAST);

   // Hold moves to the shift register either from IDLE or at the very
   // end of the stop period, so queued bytes follow with no idle gap.
   assign load = hold_full &
                 ((state == IDLE) |
                  ((state == STOP) & bit_end & (idx == STOP_LAST)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cycle_cnt <= '0;
         idx       <= '0;
         shift     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (accept)
            hold <= host.data;
         hold_full <= accept | (hold_full & ~load);
         if (load)
            shift <= hold;

         unique case (state)
            IDLE: begin
               cycle_cnt <= '0;
               idx       <= '0;
               if (hold_full)
                  state <= START;
            end
            START: begin
               if (bit_end) begin
                  cycle_cnt <= '0;
                  idx       <= '0;
                  state     <= DATA;
               end else begin
                  cycle_cnt <= cycle_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cycle_cnt <= '0;
                  if (idx == 3'd7) begin
                     idx <= '0;
`ifdef UART_XMT_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + CW'(1);
               end
            end
`ifdef UART_XMT_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cycle_cnt <= '0;
                  idx       <= '0;
                  state     <= STOP;
               end else begin
                  cycle_cnt <= cycle_cnt + CW'(1);
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cycle_cnt <= '0;
                  if (idx == STOP_LAST) begin
                     idx   <= '0;
                     state <= hold_full ? START : IDLE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line level implied by the current state; registered below so the
   // pin never sees a combinational path.
   always_comb begin
      txd_n = 1'b1;
      unique case (state)
         START:  txd_n = 1'b0;
         DATA:   txd_n = shift[idx];
`ifdef UART_XMT_PARITY_EN
         PARITY: txd_n = ^shift;
`endif
         default: txd_n = 1'b1;
      endcase
   end

   // busy is registered alongside txd_out so it drops exactly when the
   // last stop bit leaves the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd_out <= 1'b1;
         busy    <= 1'b0;
      end else begin
         txd_out <= txd_n;
         busy    <= (state != IDLE) | hold_full;
      end
   end

endmodule

// File: tb/tb_uart_xmt.sv
// tb_uart_xmt: random-stimulus bench for uart_xmt (STOP_BITS 1 and 2).
// Expected line/busy/ready come from a frame-timeline model plus a UART receiver.
module tb_uart_xmt;

   localparam int W    = 4;
   localparam int MAXC = 10000;
`ifdef UART_XMT_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_xmt_if h0 ();
   uart_xmt_if h1 ();
   logic txd0, txd1, busy0, busy1;

   uart_xmt #(.WAIT_TIME(W), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .host(h0), .txd_out(txd0), .busy(busy0)
   );
   uart_xmt #(.WAIT_TIME(W), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .host(h1), .txd_out(txd1), .busy(busy1)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit exp_txd [2][MAXC];
   bit exp_busy[2][MAXC];
   bit exp_rdy [2][MAXC];
   int line_end[2];

   logic [7:0] sbuf[2][256];
   int shead[2], stail[2];
   logic [7:0] abuf[2][256];
   int ahead[2], atail[2];
   int gap[2];
   bit rnd_gap = 0;

   bit rx_on[2];
   int rx_t[2];
   logic [7:0] rx_b[2];

   string nm[2] = '{"s1", "s2"};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic d_txd(int d);
      return (d == 0) ? txd0 : txd1;
   endfunction
   function automatic logic d_busy(int d);
      return (d == 0) ? busy0 : busy1;
   endfunction
   function automatic logic d_rdy(int d);
      return (d == 0) ? h0.ready : h1.ready;
   endfunction
   function automatic logic d_vld(int d);
      return (d == 0) ? h0.valid : h1.valid;
   endfunction

   task automatic drive(int d, logic v, logic [7:0] x);
      if (d == 0) begin
         h0.valid = v;
         h0.data  = x;
      end else begin
         h1.valid = v;
         h1.data  = x;
      end
   endtask

   // Frame bit b of byte v: start, 8 data LSB first, optional parity, stops.
   function automatic bit fbit(logic [7:0] v, int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return v[b-1];
      if (PB == 1 && b == 9) return ^v;
      return 1'b1;
   endfunction

   task automatic model_reset(int from);
      for (int d = 0; d < 2; d++) begin
         for (int k = from; k < MAXC; k++) begin
            exp_txd[d][k]  = 1'b1;
            exp_busy[d][k] = 1'b0;
            exp_rdy[d][k]  = 1'b1;
         end
         line_end[d] = 0;
         shead[d] = 0;
         stail[d] = 0;
         ahead[d] = 0;
         atail[d] = 0;
         gap[d]   = 0;
         rx_on[d] = 1'b0;
         rx_t[d]  = 0;
      end
   endtask

   // Byte accepted at edge n: line frame starts 2 clk later, or right
   // after the frame already on the line.
   task automatic accept(int d, int n, logic [7:0] v);
      int fl;
      int l;
      fl = (9 + PB + d + 1) * W;
      l  = (n + 2 > line_end[d]) ? n + 2 : line_end[d];
      for (int k = n; k <= l - 2; k++) exp_rdy[d][k] = 1'b0;
      for (int k = n + 1; k < l + fl; k++) exp_busy[d][k] = 1'b1;
      for (int k = l; k < l + fl; k++) exp_txd[d][k] = fbit(v, (k - l) / W);
      line_end[d] = l + fl;
      abuf[d][atail[d]] = v;
      atail[d]++;
   endtask

   // Receiver: sample mid-bit after a falling start edge.
   task automatic rx_step(int d, logic s);
      int k;
      if (!rx_on[d] && s == 1'b0) begin
         rx_on[d] = 1'b1;
         rx_t[d]  = 0;
      end
      if (rx_on[d]) begin
         if (rx_t[d] % W == W / 2) begin
            k = rx_t[d] / W;
            if (k == 0) begin
               chk({nm[d], "_rx_start"}, 32'(s), 32'd0);
            end else if (k <= 8) begin
               rx_b[d][k-1] = s;
`ifdef UART_XMT_PARITY_EN
            end else if (k == 9) begin
               chk({nm[d], "_rx_par"}, 32'(s), 32'(^rx_b[d]));
`endif
            end else begin
               chk({nm[d], "_rx_stop"}, 32'(s), 32'd1);
               if (ahead[d] < atail[d]) begin
                  chk({nm[d], "_rx_byte"}, 32'(rx_b[d]),
                      32'(abuf[d][ahead[d]]));
                  ahead[d]++;
               end else begin
                  chk({nm[d], "_rx_extra"}, 32'(rx_b[d]), 32'hffff_ffff);
               end
               rx_on[d] = 1'b0;
            end
         end
         rx_t[d]++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (cyc > MAXC - 200) begin
         $display("FAIL cycle_budget got=%0d exp<%0d", cyc, MAXC - 200);
         $fatal(1);
      end
      for (int d = 0; d < 2; d++) begin
         chk({nm[d], "_txd"},   32'(d_txd(d)),  32'(exp_txd[d][cyc]));
         chk({nm[d], "_busy"},  32'(d_busy(d)), 32'(exp_busy[d][cyc]));
         chk({nm[d], "_ready"}, 32'(d_rdy(d)),  32'(exp_rdy[d][cyc]));
         rx_step(d, d_txd(d));
         if (gap[d] > 0) gap[d]--;
         if (rst_n && shead[d] != stail[d] && gap[d] == 0)
            drive(d, 1'b1, sbuf[d][shead[d]]);
         else
            drive(d, 1'b0, 8'h00);
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rst_n && d_vld(d) && exp_rdy[d][cyc-1]) begin
            accept(d, cyc, sbuf[d][shead[d]]);
            shead[d]++;
            gap[d] = rnd_gap ? int'($urandom_range(0, 60)) : 0;
         end
      end
   endtask

   task automatic push(logic [7:0] v);
      for (int d = 0; d < 2; d++) begin
         sbuf[d][stail[d]] = v;
         stail[d]++;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 4000 &&
             !(shead[0] == stail[0] && shead[1] == stail[1] &&
               cyc > line_end[0] + 2 && cyc > line_end[1] + 2)) begin
         tick();
         n++;
      end
      if (n >= 4000)
         chk("wait_idle_timeout", 32'(n), 32'd0);
      repeat (5) tick();
   endtask

   initial begin
      model_reset(0);
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      rst_n = 1'b0;
      repeat (3) tick();
      #2 rst_n = 1'b1;

      repeat (100) tick();

      push(8'hA5);
      wait_idle();

      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      wait_idle();

      rnd_gap = 1'b1;
      for (int i = 0; i < 40; i++) push(8'($urandom_range(0, 255)));
      wait_idle();
      rnd_gap = 1'b0;

      push(8'h81);
      repeat (18) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("s1_async_txd",  32'(txd0),     32'd1);
      chk("s1_async_busy", 32'(busy0),    32'd0);
      chk("s1_async_rdy",  32'(h0.ready), 32'd1);
      chk("s2_async_txd",  32'(txd1),     32'd1);
      chk("s2_async_busy", 32'(busy1),    32'd0);
      model_reset(cyc);
      repeat (3) tick();
      #2 rst_n = 1'b1;

      push(8'h42);
      push(8'h07);
      push(8'h03);
      wait_idle();

      for (int d = 0; d < 2; d++)
         chk({nm[d], "_rx_count"}, 32'(ahead[d]), 32'(atail[d]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
